// File: rtl/ccip_mmio_pkg.sv
// ccip_mmio_pkg
//   Shared definitions for the CCI-P MMIO responder: the CCI-P channel
//   structs it uses, byte offsets of the AFU register map, MMIO length
//   encodings, ERR bit positions and the read-pipeline stage-1 record.
//   No ports; imported by ccip_mmio_responder and mmio_rd_decode.
package ccip_mmio_pkg;

  // Register map, byte offsets
  localparam logic [17:0] OFF_DFH         = 18'h000;
  localparam logic [17:0] OFF_ID_L        = 18'h008;
  localparam logic [17:0] OFF_ID_H        = 18'h010;
  localparam logic [17:0] OFF_ERR         = 18'h028;
  localparam logic [17:0] OFF_RDCNT       = 18'h030;
  localparam logic [17:0] OFF_WRCNT       = 18'h038;
  localparam logic [17:0] OFF_USER_BASE   = 18'h040;
  localparam logic [17:0] OFF_STATUS_BASE = 18'h100;

  // hdr.length encodings
  localparam logic [1:0] LEN_4B  = 2'd0;
  localparam logic [1:0] LEN_8B  = 2'd1;
  localparam logic [1:0] LEN_64B = 2'd2;

  // ERR bit indices
  localparam int ERR_WR_64B       = 0;
  localparam int ERR_RDWR_COLLIDE = 1;
  localparam int ERR_RD_64B       = 2;
  localparam int ERR_W            = 3;

  typedef struct packed {
    logic [15:0] address;   // dword address
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
    logic        valid;
  } t_rd_stage1;

  // Byte offset -> qword index (matches hdr.address[15:1])
  function automatic logic [14:0] qw_idx(input logic [17:0] off);
    return 15'(off >> 3);
  endfunction

endpackage

// File: rtl/mmio_rd_decode.sv
// mmio_rd_decode
//   Combinational qword-index to read-data mux feeding read stage 1.
//   Ports:
//     i_qidx      qword index of the read (hdr.address[15:1])
//     i_user_csr  current user control registers
//     i_status    read-only status words
//     i_err       ERR register, zero-extended to 64 bits
//     i_rd_cnt    read counter (tied 0 when counters are not built)
//     i_wr_cnt    write counter (tied 0 when counters are not built)
//     o_data      qword at that index, 0 for unmapped addresses
module mmio_rd_decode
  import ccip_mmio_pkg::*;
#(
  parameter logic [63:0] AFU_DFH      = 64'h1000_0000_0000_0001,
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0,
  parameter int          NUM_USER_CSR = 8,
  parameter int          NUM_STATUS   = 4
) (
  input  logic [14:0]                   i_qidx,
  input  logic [NUM_USER_CSR-1:0][63:0] i_user_csr,
  input  logic [NUM_STATUS-1:0][63:0]   i_status,
  input  logic [63:0]                   i_err,
  input  logic [63:0]                   i_rd_cnt,
  input  logic [63:0]                   i_wr_cnt,
  output logic [63:0]                   o_data
);

  always_comb begin
    o_data = '0;
    if (i_qidx == qw_idx(OFF_DFH))   o_data = AFU_DFH;
    if (i_qidx == qw_idx(OFF_ID_L))  o_data = AFU_ID_L;
    if (i_qidx == qw_idx(OFF_ID_H))  o_data = AFU_ID_H;
    if (i_qidx == qw_idx(OFF_ERR))   o_data = i_err;
    if (i_qidx == qw_idx(OFF_RDCNT)) o_data = i_rd_cnt;
    if (i_qidx == qw_idx(OFF_WRCNT)) o_data = i_wr_cnt;
    for (int i = 0; i < NUM_USER_CSR; i++)
      if (i_qidx == qw_idx(OFF_USER_BASE) + 15'(i)) o_data = i_user_csr[i];
    for (int i = 0; i < NUM_STATUS; i++)
      if (i_qidx == qw_idx(OFF_STATUS_BASE) + 15'(i)) o_data = i_status[i];
  end

endmodule

// File: rtl/ccip_mmio_responder.sv
// ccip_mmio_responder
//   CCI-P MMIO target: decodes MMIO reads/writes on Rx c0, holds the AFU
//   header, user CSRs and a sticky W1C error register, and answers reads on
//   Tx c2 two cycles after the request.
//   Build option: define MMIO_ACCESS_COUNTERS_EN to add 64-bit read/write
//   access counters at 0x030/0x038 (otherwise those addresses read 0).
//   Ports:
//     pClk         clock, rising edge
//     SoftReset_n  synchronous active-low reset
//     cp2af_c0Rx   MMIO request channel
//     af2cp_c2Tx   MMIO read response channel
//     user_csr     user control register values
//     user_csr_wr  per-register write strobe, one cycle after the write
//     status_in    read-only status words
module ccip_mmio_responder
  import ccip_mmio_pkg::*;
#(
  parameter logic [63:0] AFU_DFH      = 64'h1000_0000_0000_0001,
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0,
  parameter int          NUM_USER_CSR = 8,
  parameter int          NUM_STATUS   = 4
) (
  input  logic                          pClk,
  input  logic                          SoftReset_n,
  input  t_if_ccip_c0_Rx                cp2af_c0Rx,
  output t_if_ccip_c2_Tx                af2cp_c2Tx,
  output logic [NUM_USER_CSR-1:0][63:0] user_csr,
  output logic [NUM_USER_CSR-1:0]       user_csr_wr,
  input  logic [NUM_STATUS-1:0][63:0]   status_in
);

  t_ccip_c0_ReqMmioHdr           w_hdr;
  logic [14:0]                   w_qidx;
  logic                          w_dsel;
  logic                          w_rd_req, w_wr, w_rd, w_wr_ok;
  logic                          w_len_ok;
  logic [63:0]                   w_wdata;
  logic [ERR_W-1:0]              w_err_set, w_err_clr;
  logic [NUM_USER_CSR-1:0]       w_csr_hit;
  logic [63:0]                   w_rd_q, w_rd_fmt;
  logic [63:0]                   w_rd_cnt, w_wr_cnt;
  logic                          w_unused;

  logic [NUM_USER_CSR-1:0][63:0] r_csr;
  logic [NUM_USER_CSR-1:0]       r_csr_wr;
  logic [ERR_W-1:0]              r_err;
  t_rd_stage1                    r_s1;
  t_if_ccip_c2_Tx                r_c2;

  assign w_hdr    = cp2af_c0Rx.hdr;
  assign w_qidx   = w_hdr.address[15:1];
  assign w_dsel   = w_hdr.address[0];
  assign w_wdata  = cp2af_c0Rx.data[63:0];
  assign w_len_ok = (w_hdr.length == LEN_4B) || (w_hdr.length == LEN_8B);
  assign w_wr     = cp2af_c0Rx.mmioWrValid;
  assign w_rd_req = cp2af_c0Rx.mmioRdValid;
  // A read colliding with a write is dropped; the write still happens.
  assign w_rd     = w_rd_req & ~w_wr;
  assign w_wr_ok  = w_wr & w_len_ok;

  assign w_unused = ^{cp2af_c0Rx.data[511:64], w_hdr.rsvd};

  // ---------------- error register ----------------
  always_comb begin
    w_err_set                   = '0;
    w_err_set[ERR_WR_64B]       = w_wr & ~w_len_ok;
    w_err_set[ERR_RDWR_COLLIDE] = w_rd_req & w_wr;
    w_err_set[ERR_RD_64B]       = w_rd & ~w_len_ok;
    w_err_clr = '0;
    // W1C bits live in the low dword; an upper-dword 4B write clears nothing
    if (w_wr_ok && (w_qidx == qw_idx(OFF_ERR)) &&
        ((w_hdr.length == LEN_8B) || !w_dsel))
      w_err_clr = w_wdata[ERR_W-1:0];
  end

  always_ff @(posedge pClk) begin
    if (!SoftReset_n) r_err <= '0;
    else              r_err <= (r_err & ~w_err_clr) | w_err_set;  // set wins
  end

  // ---------------- user CSRs ----------------
  always_comb begin
    w_csr_hit = '0;
    for (int i = 0; i < NUM_USER_CSR; i++)
      w_csr_hit[i] = w_wr_ok && (w_qidx == qw_idx(OFF_USER_BASE) + 15'(i));
  end

  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      r_csr    <= '0;
      r_csr_wr <= '0;
    end else begin
      r_csr_wr <= w_csr_hit;
      for (int i = 0; i < NUM_USER_CSR; i++) begin
        if (w_csr_hit[i]) begin
          if (w_hdr.length == LEN_8B) r_csr[i]        <= w_wdata;
          else if (w_dsel)            r_csr[i][63:32] <= w_wdata[31:0];
          else                        r_csr[i][31:0]  <= w_wdata[31:0];
        end
      end
    end
  end

  assign user_csr    = r_csr;
  assign user_csr_wr = r_csr_wr;

  // ---------------- access counters ----------------
`ifdef MMIO_ACCESS_COUNTERS_EN
  logic [63:0] r_rd_cnt, r_wr_cnt;

  // Dropped reads are not counted; ignored 64B writes are.
  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd) r_rd_cnt <= r_rd_cnt + 64'd1;
      if (w_wr) r_wr_cnt <= r_wr_cnt + 64'd1;
    end
  end

  assign w_rd_cnt = r_rd_cnt;
  assign w_wr_cnt = r_wr_cnt;
`else
  assign w_rd_cnt = '0;
  assign w_wr_cnt = '0;
`endif

  // ---------------- read path ----------------
  mmio_rd_decode #(
    .AFU_DFH      (AFU_DFH),
    .AFU_ID_L     (AFU_ID_L),
    .AFU_ID_H     (AFU_ID_H),
    .NUM_USER_CSR (NUM_USER_CSR),
    .NUM_STATUS   (NUM_STATUS)
  ) u_dec (
    .i_qidx     (w_qidx),
    .i_user_csr (r_csr),
    .i_status   (status_in),
    .i_err      ({{(64-ERR_W){1'b0}}, r_err}),
    .i_rd_cnt   (w_rd_cnt),
    .i_wr_cnt   (w_wr_cnt),
    .o_data     (w_rd_q)
  );

  // 4B reads return the selected dword zero-extended; bad lengths return 0.
  always_comb begin
    w_rd_fmt = '0;
    if (w_hdr.length == LEN_8B)
      w_rd_fmt = w_rd_q;
    else if (w_hdr.length == LEN_4B)
      w_rd_fmt = {32'b0, w_dsel ? w_rd_q[63:32] : w_rd_q[31:0]};
  end

  always_ff @(posedge pClk) begin
    if (!SoftReset_n) begin
      r_s1 <= '0;
      r_c2 <= '0;
    end else begin
      r_s1.valid       <= w_rd;
      r_s1.tid         <= w_hdr.tid;
      r_s1.data        <= w_rd_fmt;
      r_c2.mmioRdValid <= r_s1.valid;
      r_c2.hdr.tid     <= r_s1.tid;
      r_c2.data        <= r_s1.data;
    end
  end

  assign af2cp_c2Tx = r_c2;

endmodule
